// File: rtl/escreveinstrucao_pkg.sv
// Shared definitions for the instruction-memory program loader and the fetch memory.
package escreveinstrucao_pkg;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        RECEBE    = 2'd1,
        ESCREVE   = 2'd2,
        CONCLUIDO = 2'd3
    } estado_carga_t;

    localparam int BYTES_POR_PALAVRA = 4;

    // Instruction memory geometry, shared with the fetch side (word-indexed by PC).
    localparam int IMEM_PROFUNDIDADE = 31;
    localparam int IMEM_END_W        = 5;

endpackage

// File: rtl/escreveinstrucao_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface escreveinstrucao_if
    import escreveinstrucao_pkg::*;
#(
    parameter int END_W = IMEM_END_W
);
    logic             iniciar;
    logic [END_W:0]   num_palavras;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             escrita_en;
    logic [END_W-1:0] escrita_endereco;
    logic [31:0]      escrita_dado;
    logic             ocupado;
    logic             pronto;
    logic             erro;

    modport slave (
        input  iniciar, num_palavras, byte_in, byte_valid,
        output byte_ready, escrita_en, escrita_endereco, escrita_dado,
               ocupado, pronto, erro
    );

    modport master (
        output iniciar, num_palavras, byte_in, byte_valid,
        input  byte_ready, escrita_en, escrita_endereco, escrita_dado,
               ocupado, pronto, erro
    );
endinterface

// File: rtl/escreveinstrucao_empacota_bytes.sv
// Little-endian 4-byte assembler: byte k lands in bits [8k+7:8k]; the finished word
// is captured in its own register so it stays stable while the next word arrives.
module empacota_bytes
    import escreveinstrucao_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        limpa_i,
    input  logic        aceita_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] palavra_o,
    output logic        palavra_completa_o
);
    localparam int CNT_W = $clog2(BYTES_POR_PALAVRA);
    localparam int ACC_W = 8 * (BYTES_POR_PALAVRA - 1);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(BYTES_POR_PALAVRA - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [31:0]      palavra_q, palavra_d;

    always_comb begin
        cnt_d              = cnt_q;
        acc_d              = acc_q;
        palavra_d          = palavra_q;
        palavra_completa_o = aceita_i && (cnt_q == ULTIMO);
        if (limpa_i) begin
            cnt_d = '0;
        end else if (aceita_i) begin
            // Counter wraps naturally to 0 on the last byte of a word.
            cnt_d = cnt_q + 1'b1;
            acc_d = {byte_i, acc_q[ACC_W-1:8]};
            if (palavra_completa_o) begin
                palavra_d = {byte_i, acc_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            palavra_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            palavra_q <= palavra_d;
        end
    end

    assign palavra_o = palavra_q;

endmodule

// File: rtl/escreveinstrucao.sv
// Program loader: packs the incoming byte stream into 32-bit words and writes them to
// consecutive instruction-memory addresses; all outputs are registered or state-decoded.
module escreveinstrucao
    import escreveinstrucao_pkg::*;
#(
    parameter int PROFUNDIDADE = IMEM_PROFUNDIDADE,
    parameter int END_W        = IMEM_END_W
)(
    input  logic               clk,
    input  logic               rst_n,
    escreveinstrucao_if.slave  bus
);
    localparam logic [END_W:0] PROF_W = (END_W + 1)'(PROFUNDIDADE);

    estado_carga_t    estado_q, estado_d;
    logic [END_W:0]   alvo_q, alvo_d;
    logic [END_W:0]   palavras_q, palavras_d;
    logic [END_W-1:0] endereco_q, endereco_d;
    logic             erro_q, erro_d;
    logic [END_W:0]   alvo_novo;
    logic             aceita;
    logic             limpa;
    logic             completa;
    logic [31:0]      palavra;

    // Oversized requests are clamped to the memory depth and flagged.
    assign alvo_novo = (bus.num_palavras > PROF_W) ? PROF_W : bus.num_palavras;
    assign aceita    = (estado_q == RECEBE) && bus.byte_valid;

    empacota_bytes u_empacota (
        .clk                (clk),
        .rst_n              (rst_n),
        .limpa_i            (limpa),
        .aceita_i           (aceita),
        .byte_i             (bus.byte_in),
        .palavra_o          (palavra),
        .palavra_completa_o (completa)
    );

    always_comb begin
        estado_d   = estado_q;
        alvo_d     = alvo_q;
        palavras_d = palavras_q;
        endereco_d = endereco_q;
        erro_d     = erro_q;
        limpa      = 1'b0;
        case (estado_q)
            OCIOSO, CONCLUIDO: begin
                if (bus.iniciar) begin
                    alvo_d     = alvo_novo;
                    erro_d     = bus.num_palavras > PROF_W;
                    palavras_d = '0;
                    limpa      = 1'b1;
                    estado_d   = (alvo_novo == '0) ? CONCLUIDO : RECEBE;
                end
            end
            RECEBE: begin
                if (completa) begin
                    endereco_d = palavras_q[END_W-1:0];
                    estado_d   = ESCREVE;
                end
            end
            ESCREVE: begin
                palavras_d = palavras_q + 1'b1;
                estado_d   = (palavras_d == alvo_q) ? CONCLUIDO : RECEBE;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q   <= OCIOSO;
            alvo_q     <= '0;
            palavras_q <= '0;
            endereco_q <= '0;
            erro_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            alvo_q     <= alvo_d;
            palavras_q <= palavras_d;
            endereco_q <= endereco_d;
            erro_q     <= erro_d;
        end
    end

    assign bus.byte_ready       = (estado_q == RECEBE);
    assign bus.escrita_en       = (estado_q == ESCREVE);
    assign bus.ocupado          = (estado_q == RECEBE) || (estado_q == ESCREVE);
    assign bus.pronto           = (estado_q == CONCLUIDO);
    assign bus.erro             = erro_q;
    assign bus.escrita_endereco = endereco_q;
    assign bus.escrita_dado     = palavra;

endmodule

// File: tb/tb_escreveinstrucao.sv
// Directed and randomized checks of the program loader against a byte-list memory model.
module tb_escreveinstrucao;
    localparam int PROF = 31;
    localparam int EW   = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    escreveinstrucao_if #(.END_W(EW)) bus ();

    escreveinstrucao #(.PROFUNDIDADE(PROF), .END_W(EW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          addr;
        logic [31:0] dado;
        int          cyc;
    } wr_t;

    wr_t wr_q[$];
    int  cyc   = 0;
    int  tests = 0;
    int  fails = 0;
    logic [7:0] prog[$] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.escrita_en === 1'b1) begin
            wr_t w;
            w.addr = int'(bus.escrita_endereco);
            w.dado = bus.escrita_dado;
            w.cyc  = cyc;
            wr_q.push_back(w);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, {bus.byte_ready, bus.escrita_en, bus.ocupado, bus.pronto, bus.erro}, 0);
        check({tag, "_end"}, bus.escrita_endereco, 0);
        check({tag, "_dado"}, bus.escrita_dado, 0);
    endtask

    task automatic pulsa_iniciar(input int n);
        bus.iniciar      = 1'b1;
        bus.num_palavras = 6'(n);
        ciclo();
        bus.iniciar      = 1'b0;
    endtask

    // modo 0: continuous valid, 1: alternate cycles, 2: random
    task automatic envia(input logic [7:0] s[$], input int modo);
        int i      = 0;
        int gastos = 0;
        bit tog    = 1'b1;
        bit acc;
        while (i < s.size() && gastos < 2000) begin
            bus.byte_in = s[i];
            case (modo)
                0:       bus.byte_valid = 1'b1;
                1: begin bus.byte_valid = tog; tog = !tog; end
                default: bus.byte_valid = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            acc = bus.byte_valid && bus.byte_ready;
            ciclo();
            if (acc) i++;
            gastos++;
        end
        bus.byte_valid = 1'b0;
        if (i < s.size()) check("timeout_envia", i, s.size());
    endtask

    // Memory model: word w holds bytes 4w..4w+3, little-endian, at address w.
    task automatic confere(input string tag, input logic [7:0] s[$], input int n);
        check({tag, "_num_escritas"}, wr_q.size(), n);
        for (int w = 0; w < n && w < wr_q.size(); w++) begin
            logic [31:0] esp;
            esp = 32'd0;
            for (int k = 0; k < 4; k++) esp = esp + (32'(s[4*w+k]) << (8*k));
            check({tag, "_end"}, wr_q[w].addr, w);
            check({tag, "_dado"}, wr_q[w].dado, esp);
        end
    endtask

    task automatic fim_da_carga(input string tag);
        @(negedge clk);
        check({tag, "_ultima_escrita"}, bus.escrita_en, 1);
        check({tag, "_pronto_ainda_0"}, bus.pronto, 0);
        ciclo();
        @(negedge clk);
        check({tag, "_pronto"}, bus.pronto, 1);
        check({tag, "_ready_0"}, bus.byte_ready, 0);
        ciclo();
    endtask

    initial begin
        logic [7:0] s[$];
        int n;
        bus.iniciar      = 1'b0;
        bus.num_palavras = '0;
        bus.byte_in      = '0;
        bus.byte_valid   = 1'b0;

        rst_n = 1'b0;
        ciclo();
        ciclo();
        @(negedge clk);
        check_zero("reset");
        ciclo();
        rst_n = 1'b1;
        ciclo();

        // Two-word load, continuous valid
        wr_q.delete();
        pulsa_iniciar(2);
        @(negedge clk);
        check("t1_ready_apos_iniciar", bus.byte_ready, 1);
        check("t1_ocupado", bus.ocupado, 1);
        ciclo();
        envia(prog, 0);
        fim_da_carga("t1");
        confere("t1", prog, 2);
        if (wr_q.size() == 2) check("t1_intervalo", wr_q[1].cyc - wr_q[0].cyc, 5);

        // Gapped valid, restarted from CONCLUIDO
        wr_q.delete();
        pulsa_iniciar(2);
        envia(prog, 1);
        fim_da_carga("t2");
        confere("t2", prog, 2);

        // Zero words
        rst_n = 1'b0;
        ciclo();
        rst_n = 1'b1;
        @(negedge clk);
        check("t3_pronto_antes", bus.pronto, 0);
        ciclo();
        wr_q.delete();
        pulsa_iniciar(0);
        @(negedge clk);
        check("t3_pronto", bus.pronto, 1);
        check("t3_ocupado", bus.ocupado, 0);
        check("t3_erro", bus.erro, 0);
        repeat (3) ciclo();
        check("t3_sem_escritas", wr_q.size(), 0);

        // Oversized count is clamped to the memory depth
        wr_q.delete();
        pulsa_iniciar(40);
        @(negedge clk);
        check("t4_erro_cedo", bus.erro, 1);
        ciclo();
        s.delete();
        for (int i = 0; i < 4*PROF; i++) s.push_back(8'($urandom));
        envia(s, 0);
        fim_da_carga("t4");
        check("t4_erro", bus.erro, 1);
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_ready_apos_fim", bus.byte_ready, 0);
            ciclo();
        end
        bus.byte_valid = 1'b0;
        confere("t4", s, PROF);

        // Reset in the middle of the second word
        wr_q.delete();
        pulsa_iniciar(2);
        s = prog[0:5];
        envia(s, 0);
        rst_n = 1'b0;
        ciclo();
        @(negedge clk);
        check_zero("t5_reset");
        ciclo();
        rst_n = 1'b1;
        repeat (3) ciclo();
        check("t5_uma_escrita", wr_q.size(), 1);
        wr_q.delete();
        pulsa_iniciar(1);
        s = prog[4:7];
        envia(s, 0);
        fim_da_carga("t5b");
        confere("t5b", s, 1);

        // iniciar while receiving is ignored
        wr_q.delete();
        pulsa_iniciar(2);
        s = prog[0:1];
        envia(s, 0);
        pulsa_iniciar(5);
        @(negedge clk);
        check("t6_ocupado", bus.ocupado, 1);
        check("t6_ready", bus.byte_ready, 1);
        check("t6_erro", bus.erro, 0);
        ciclo();
        s = prog[2:7];
        envia(s, 0);
        fim_da_carga("t6");
        confere("t6", prog, 2);

        // Reload from CONCLUIDO
        wr_q.delete();
        pulsa_iniciar(1);
        @(negedge clk);
        check("t7_pronto_cai", bus.pronto, 0);
        check("t7_ocupado", bus.ocupado, 1);
        ciclo();
        s.delete();
        for (int i = 0; i < 4; i++) s.push_back(8'($urandom));
        envia(s, 0);
        fim_da_carga("t7");
        confere("t7", s, 1);

        // Randomized loads with random valid gaps
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 6);
            s.delete();
            for (int i = 0; i < 4*n; i++) s.push_back(8'($urandom));
            wr_q.delete();
            pulsa_iniciar(n);
            envia(s, 2);
            fim_da_carga("rnd");
            check("rnd_erro", bus.erro, 0);
            confere("rnd", s, n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/escreveinstrucao.md
# escreveinstrucao

Program loader for the instruction memory: receives the program as a byte stream over a valid/ready handshake and packs each 4 bytes into one 32-bit instruction word. Writes each word into the instruction memory's write port at consecutive word addresses. Asserts `pronto` when the whole program is stored, so the control FSM can leave reset and start fetching from PC = 0. It is the write side of the instruction memory, which is word-indexed by PC.

## Interface
- `PROFUNDIDADE`, 31: number of 32-bit words in instruction memory.
- `END_W`, 5: address width; must satisfy 2^END_W ≥ PROFUNDIDADE.
- `clk` input 1: single clock, all logic on posedge.
- `rst_n` input 1: synchronous, active-low reset.
- `iniciar` input 1: one-cycle start pulse; sampled only in OCIOSO or CONCLUIDO.
- `num_palavras` input END_W+1: number of words to load; latched on accepted `iniciar`.
- `byte_in` input 8: stream byte.
- `byte_valid` input 1: `byte_in` is valid.
- `byte_ready` output 1: loader accepts a byte this cycle.
- `escrita_en` output 1: memory write strobe, one cycle per word.
- `escrita_endereco` output END_W: word address, equal to the PC index used by fetch.
- `escrita_dado` output 32: assembled instruction.
- `ocupado` output 1: load in progress.
- `pronto` output 1: program fully written; level signal.
- `erro` output 1: `num_palavras` exceeded PROFUNDIDADE, so the load was truncated; level signal.

## Operation
- States: OCIOSO, RECEBE, ESCREVE, CONCLUIDO.
- **OCIOSO**
  - On `iniciar`: latch `alvo` = min(`num_palavras`, PROFUNDIDADE).
  - Set `erro` = (`num_palavras` > PROFUNDIDADE).
  - Clear word counter and byte counter.
  - If `alvo` = 0, go to CONCLUIDO; otherwise go to RECEBE.
- **RECEBE**
  - `byte_ready` = 1.
  - A byte is accepted when `byte_valid` and `byte_ready` are both high at the edge.
  - Packing is little-endian: byte k (k = 0..3) goes to bits [8k+7:8k].
  - On the 4th accepted byte, go to ESCREVE.
- **ESCREVE**
  - Exactly one cycle.
  - `escrita_en` = 1, `escrita_endereco` = word counter, `escrita_dado` = assembled word.
  - `byte_ready` = 0.
  - Increment the word counter. If the new count equals `alvo`, go to CONCLUIDO; otherwise go to RECEBE with the byte counter at 0.
- **CONCLUIDO**
  - `pronto` = 1 and `byte_ready` = 0.
  - A new `iniciar` restarts the load: same actions as in OCIOSO, and `pronto` drops on the next cycle.
- `ocupado` = 1 in RECEBE and ESCREVE.
- `iniciar` is ignored in RECEBE and ESCREVE.
- Any bytes beyond `alvo`·4 are never accepted (`byte_ready` stays 0).
- Counters:
  - Word counter is END_W+1 bits; it never wraps because `alvo` ≤ PROFUNDIDADE.
  - Byte counter is 2 bits and wraps 3→0 on entry to ESCREVE.

## Timing
- Reset (`rst_n` = 0 at posedge):
  - State goes to OCIOSO.
  - All outputs go to 0: `byte_ready`, `escrita_en`, `escrita_endereco`, `escrita_dado`, `ocupado`, `pronto`, `erro`.
  - Reset mid-load abandons the partial word; words already written stay in memory.
- `iniciar` at edge t: `byte_ready` is high from cycle t+1.
- Write latency: 4th byte accepted at edge t → `escrita_en` high during cycle t+1 → `byte_ready` high again in cycle t+2.
- Peak throughput is one word per 5 cycles.
- Last word: `escrita_en` during cycle t+1, `pronto` high from cycle t+2.
- Outputs are registered or decoded from state only; no combinational path from `byte_valid` to `byte_ready`.
- `escrita_dado` and `escrita_endereco` hold their last values outside ESCREVE; the memory must qualify writes with `escrita_en`.

## Structure
- A shared package holds:
  - the state encoding `estado_carga_t` (OCIOSO = 2'd0, RECEBE = 2'd1, ESCREVE = 2'd2, CONCLUIDO = 2'd3);
  - the constant `BYTES_POR_PALAVRA` = 4.
- The default PROFUNDIDADE matches the fetch memory depth and lives alongside the instruction-memory constants.
- One sub-module, `empacota_bytes`: 4-byte little-endian shift/assembly register with byte counter and `palavra_completa` output. The top-level FSM owns the handshake and the address counter.

## Test plan
- **Two-word load, continuous valid.** Reset, then `iniciar` with `num_palavras` = 2 and bytes 13,00,50,00,93,00,10,00.
  - Writes 0x00500013 at address 0 and 0x00100093 at address 1.
  - Exactly 2 `escrita_en` pulses, 5 cycles apart; `pronto` = 1 two cycles after the last byte.
- **Gapped valid.** Same stream with `byte_valid` low on alternate cycles.
  - Identical memory contents; no byte duplicated or dropped.
- **Zero and oversized counts.**
  - `num_palavras` = 0: `pronto` = 1 on the cycle after `iniciar`, no writes.
  - `num_palavras` = 40 with PROFUNDIDADE = 31: exactly 31 writes, addresses 0..30, `erro` = 1, then `byte_ready` = 0.
- **Mid-load reset.** `rst_n` = 0 after 6 bytes.
  - All outputs 0 on the next cycle, no second write.
  - A subsequent `iniciar` restarts at address 0.
- **`iniciar` while busy, then reload.**
  - Pulse during RECEBE is ignored and the counters are unchanged.
  - `iniciar` in CONCLUIDO with `num_palavras` = 1 clears `pronto`, rewrites address 0, and sets `pronto` again.
